// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one-cycle fetch/load/store requests into the
// readM/writeM memory handshake, captures the instruction register and MDR,
// and reports completion with a done pulse or abort with an err pulse.
module mem_access_unit #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 Reset_N,
  input  logic                 if_req,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] mdr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WORD_SIZE-1:0] num_fetch
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

  // Abort fires on the edge where the wait counter would reach TIMEOUT.
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tcnt;
  logic       any_req;
  logic       resp;
  logic       tmo;

  assign any_req = if_req | rd_req | wr_req;
  assign tmo     = (tcnt == TLAST);

  // Matching response for the current access; wrong-type responses are ignored.
  always_comb begin
    resp = 1'b0;
    case (state)
      FETCH, LOAD: resp = inputReady;
      STORE:       resp = ackOutput;
      default:     resp = 1'b0;
    endcase
  end

  // Access FSM with registered strobes, data registers and status pulses.
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      state       <= IDLE;
      readM       <= 1'b0;
      writeM      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instruction <= '0;
      mdr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      num_fetch   <= '0;
      tcnt        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (wr_req) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            writeM    <= 1'b1;
            busy      <= 1'b1;
            state     <= STORE;
          end else if (rd_req) begin
            mem_addr <= addr;
            readM    <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end else if (if_req) begin
            mem_addr <= pc;
            readM    <= 1'b1;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH, LOAD, STORE: begin
          if (resp) begin
            // Completion wins over a same-cycle busy request so done and
            // err never overlap; that stray request is simply dropped.
            if (state == FETCH) begin
              instruction <= mem_rdata;
              num_fetch   <= num_fetch + 1'b1;
            end
            if (state == LOAD) mdr <= mem_rdata;
            readM  <= 1'b0;
            writeM <= 1'b0;
            done   <= 1'b1;
            tcnt   <= '0;
            state  <= DONE;
          end else if (tmo) begin
            readM  <= 1'b0;
            writeM <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
            tcnt   <= '0;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
            err  <= any_req;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          err   <= any_req;
          tcnt  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch/load/store handshakes, priority,
// busy-request errors, timeout, mid-access reset and fetch counter wrap.
// A second, 4-bit-wide instance follows the same stimulus so that the fetch
// counter wrap is reached in a handful of fetches.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        Reset_N;
  logic        if_req, rd_req, wr_req;
  logic [15:0] pc, addr, wdata, mem_rdata;
  logic        inputReady, ackOutput;
  logic        readM, writeM, busy, done, err;
  logic [15:0] mem_addr, mem_wdata, instruction, mdr, num_fetch;

  logic        s_readM, s_writeM, s_busy, s_done, s_err;
  logic [3:0]  s_mem_addr, s_mem_wdata, s_instruction, s_mdr, s_num_fetch;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_SIZE(16), .TIMEOUT(4)) u_dut (
    .clk(clk), .Reset_N(Reset_N), .if_req(if_req), .rd_req(rd_req),
    .wr_req(wr_req), .pc(pc), .addr(addr), .wdata(wdata), .readM(readM),
    .writeM(writeM), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .inputReady(inputReady), .ackOutput(ackOutput),
    .instruction(instruction), .mdr(mdr), .busy(busy), .done(done),
    .err(err), .num_fetch(num_fetch)
  );

  mem_access_unit #(.WORD_SIZE(4), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .Reset_N(Reset_N), .if_req(if_req), .rd_req(rd_req),
    .wr_req(wr_req), .pc(pc[3:0]), .addr(addr[3:0]), .wdata(wdata[3:0]),
    .readM(s_readM), .writeM(s_writeM), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata[3:0]),
    .inputReady(inputReady), .ackOutput(ackOutput),
    .instruction(s_instruction), .mdr(s_mdr), .busy(s_busy), .done(s_done),
    .err(s_err), .num_fetch(s_num_fetch)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] d, input int dly);
    pc = a; if_req = 1'b1;
    tick;
    if_req = 1'b0;
    repeat (dly) tick;
    mem_rdata = d; inputReady = 1'b1;
    tick;
    inputReady = 1'b0;
    chk("fetch_done", {15'd0, done}, 16'd1);
    tick;
  endtask

  initial begin
    Reset_N = 1'b0; if_req = 0; rd_req = 0; wr_req = 0;
    pc = 0; addr = 0; wdata = 0; mem_rdata = 0; inputReady = 0; ackOutput = 0;
    tick; tick;
    chk("rst_readM", {15'd0, readM}, 16'd0);
    chk("rst_writeM", {15'd0, writeM}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done_err", {14'd0, done, err}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_mdr", mdr, 16'h0000);
    chk("rst_nfetch", num_fetch, 16'h0000);
    Reset_N = 1'b1;
    tick;

    // Fetch with a two-cycle memory delay, plus a request during DONE
    pc = 16'h0010; if_req = 1'b1;
    tick;
    if_req = 1'b0;
    chk("f_readM", {15'd0, readM}, 16'd1);
    chk("f_mem_addr", mem_addr, 16'h0010);
    chk("f_busy", {15'd0, busy}, 16'd1);
    tick; tick;
    chk("f_wait_readM", {15'd0, readM}, 16'd1);
    chk("f_wait_done", {15'd0, done}, 16'd0);
    mem_rdata = 16'h6A05; inputReady = 1'b1;
    tick;
    inputReady = 1'b0;
    chk("f_done", {15'd0, done}, 16'd1);
    chk("f_instr", instruction, 16'h6A05);
    chk("f_readM_low", {15'd0, readM}, 16'd0);
    chk("f_nfetch", num_fetch, 16'd1);
    if_req = 1'b1;
    tick;
    if_req = 1'b0;
    chk("f_done_once", {15'd0, done}, 16'd0);
    chk("f_busy_low", {15'd0, busy}, 16'd0);
    chk("f_doneReq_err", {15'd0, err}, 16'd1);
    chk("f_doneReq_drop", {15'd0, readM}, 16'd0);
    tick;
    chk("f_err_once", {15'd0, err}, 16'd0);

    // Store, ack after one cycle
    addr = 16'h0030; wdata = 16'hBEEF; wr_req = 1'b1;
    tick;
    wr_req = 1'b0;
    chk("s_writeM", {15'd0, writeM}, 16'd1);
    chk("s_mem_addr", mem_addr, 16'h0030);
    chk("s_mem_wdata", mem_wdata, 16'hBEEF);
    tick;
    ackOutput = 1'b1;
    tick;
    ackOutput = 1'b0;
    chk("s_done", {15'd0, done}, 16'd1);
    chk("s_writeM_low", {15'd0, writeM}, 16'd0);
    tick;
    chk("s_busy_low", {15'd0, busy}, 16'd0);

    // Load back from the same address
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    chk("l_readM", {15'd0, readM}, 16'd1);
    mem_rdata = 16'hBEEF; inputReady = 1'b1;
    tick;
    inputReady = 1'b0;
    chk("l_done", {15'd0, done}, 16'd1);
    chk("l_mdr", mdr, 16'hBEEF);
    chk("l_instr_kept", instruction, 16'h6A05);
    tick;

    // All three requests together: store wins
    pc = 16'h0050; addr = 16'h0040; wdata = 16'h1234;
    if_req = 1; rd_req = 1; wr_req = 1;
    tick;
    if_req = 0; rd_req = 0; wr_req = 0;
    chk("p_writeM", {15'd0, writeM}, 16'd1);
    chk("p_readM", {15'd0, readM}, 16'd0);
    chk("p_mem_addr", mem_addr, 16'h0040);
    // Busy request plus a wrong-type response while storing
    rd_req = 1'b1; inputReady = 1'b1; mem_rdata = 16'hDEAD;
    tick;
    rd_req = 1'b0; inputReady = 1'b0;
    chk("p_busy_err", {15'd0, err}, 16'd1);
    chk("p_still_store", {15'd0, writeM}, 16'd1);
    chk("p_no_done", {15'd0, done}, 16'd0);
    chk("p_mdr_kept", mdr, 16'hBEEF);
    tick;
    chk("p_err_once", {15'd0, err}, 16'd0);
    ackOutput = 1'b1;
    tick;
    ackOutput = 1'b0;
    chk("p_done", {15'd0, done}, 16'd1);
    chk("p_done_no_err", {15'd0, err}, 16'd0);
    tick;

    // Timeout: memory never answers a fetch
    pc = 16'h0070; if_req = 1'b1;
    tick;
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t_wait_err", {15'd0, err}, 16'd0);
      chk("t_wait_readM", {15'd0, readM}, 16'd1);
    end
    tick;
    chk("t_err", {15'd0, err}, 16'd1);
    chk("t_readM", {15'd0, readM}, 16'd0);
    chk("t_busy", {15'd0, busy}, 16'd0);
    chk("t_no_done", {15'd0, done}, 16'd0);
    chk("t_instr_kept", instruction, 16'h6A05);
    chk("t_nfetch_kept", num_fetch, 16'd1);
    tick;
    chk("t_err_once", {15'd0, err}, 16'd0);

    // Reset in the middle of a load
    addr = 16'h0030; rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    chk("r_readM", {15'd0, readM}, 16'd1);
    Reset_N = 1'b0;
    tick;
    chk("r_readM_low", {15'd0, readM}, 16'd0);
    chk("r_busy", {15'd0, busy}, 16'd0);
    chk("r_mdr", mdr, 16'h0000);
    chk("r_nfetch", num_fetch, 16'h0000);
    Reset_N = 1'b1;
    tick;
    chk("r_no_done", {15'd0, done}, 16'd0);
    fetch(16'h0080, 16'h1111, 1);
    chk("r_fetch_instr", instruction, 16'h1111);
    chk("r_fetch_nfetch", num_fetch, 16'd1);

    // Fetch counter wrap, seen on the 4-bit instance after 16 fetches
    for (int i = 0; i < 14; i++) fetch(16'(i), 16'(i), 0);
    chk("w_pre_wrap", {12'd0, s_num_fetch}, 16'd15);
    fetch(16'h000E, 16'h000E, 0);
    chk("w_wrap", {12'd0, s_num_fetch}, 16'd0);
    chk("w_nfetch16", num_fetch, 16'd16);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
